// File: rtl/dmem_arb_pkg.sv
// Shared widths, port ids and pipeline register types for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    typedef struct packed {
        logic              valid;
        logic              port;
        logic              we;
        logic              err;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } issue_t;

    typedef struct packed {
        logic              valid;
        logic              port;
        logic              err;
        logic [DATA_W-1:0] rdata;
    } rsp_t;

    function automatic logic misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: both ports' request and response signals.
interface dmem_arbiter_if;
    import dmem_arb_pkg::*;

    logic              req0, we0, gnt0, rsp_valid0, rsp_err0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0, rdata0;

    logic              req1, we1, gnt1, rsp_valid1, rsp_err1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1, rdata1;

    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
        input  gnt0, rsp_valid0, rsp_err0, rdata0, gnt1, rsp_valid1, rsp_err1, rdata1
    );

    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
        output gnt0, rsp_valid0, rsp_err0, rdata0, gnt1, rsp_valid1, rsp_err1, rdata1
    );

endinterface

// File: rtl/dmem_arb_select.sv
// Two-way grant logic. DMEM_ARB_RR_EN selects round-robin; otherwise port 0 has fixed priority.
module dmem_arb_select (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

`ifdef DMEM_ARB_RR_EN
    logic last_q;  // port id of the most recent winner
    logic pick1;

    always_comb begin
        // On conflict port 1 wins only if port 0 won last.
        pick1 = req1 & (~req0 | ~last_q);
        gnt1  = rst_n & pick1;
        gnt0  = rst_n & req0 & ~pick1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (gnt0 | gnt1) begin
            last_q <= gnt1;
        end
    end
`else
    logic unused_clk;
    assign unused_clk = clk;

    always_comb begin
        gnt0 = rst_n & req0;
        gnt1 = rst_n & req1 & ~req0;
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: grant, issue stage, registered response two cycles after grant.
// Arbitration policy is chosen by DMEM_ARB_RR_EN (see dmem_arb_select).
module dmem_arbiter
    import dmem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    dmem_arbiter_if.slave     bus,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [DATA_W-1:0] MemWriteData,
    input  logic [DATA_W-1:0] MemReadData
);

    logic   gnt0, gnt1;
    logic   mem_active;
    issue_t issue_d, issue_q;
    rsp_t   rsp_d, rsp_q;

    dmem_arb_select u_select (
        .clk   (clk),
        .rst_n (rst_n),
        .req0  (bus.req0),
        .req1  (bus.req1),
        .gnt0  (gnt0),
        .gnt1  (gnt1)
    );

    assign bus.gnt0 = gnt0;
    assign bus.gnt1 = gnt1;

    always_comb begin
        issue_d = '0;
        if (gnt0) begin
            issue_d.valid = 1'b1;
            issue_d.port  = PORT_CPU;
            issue_d.we    = bus.we0;
            issue_d.err   = misaligned(bus.addr0[1:0]);
            issue_d.addr  = bus.addr0;
            issue_d.wdata = bus.wdata0;
        end else if (gnt1) begin
            issue_d.valid = 1'b1;
            issue_d.port  = PORT_DMA;
            issue_d.we    = bus.we1;
            issue_d.err   = misaligned(bus.addr1[1:0]);
            issue_d.addr  = bus.addr1;
            issue_d.wdata = bus.wdata1;
        end
    end

    // Misaligned accesses travel down the pipe only to report the error.
    assign mem_active = issue_q.valid & ~issue_q.err;

    always_comb begin
        MemRead      = mem_active & ~issue_q.we;
        MemWrite     = mem_active & issue_q.we;
        MemAddress   = mem_active ? issue_q.addr : '0;
        MemWriteData = mem_active ? issue_q.wdata : '0;
    end

    always_comb begin
        rsp_d       = '0;
        rsp_d.valid = issue_q.valid;
        rsp_d.port  = issue_q.port;
        rsp_d.err   = issue_q.err;
        rsp_d.rdata = MemRead ? MemReadData : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_q <= '0;
            rsp_q   <= '0;
        end else begin
            issue_q <= issue_d;
            rsp_q   <= rsp_d;
        end
    end

    always_comb begin
        bus.rsp_valid0 = rsp_q.valid & (rsp_q.port == PORT_CPU);
        bus.rsp_valid1 = rsp_q.valid & (rsp_q.port == PORT_DMA);
        bus.rsp_err0   = bus.rsp_valid0 & rsp_q.err;
        bus.rsp_err1   = bus.rsp_valid1 & rsp_q.err;
        bus.rdata0     = bus.rsp_valid0 ? rsp_q.rdata : '0;
        bus.rdata1     = bus.rsp_valid1 ? rsp_q.rdata : '0;
    end

endmodule
